mem_access: RTL
===============

# mem_access

Memory-access stage between the execute stage and `wb`. Non-memory instructions pass through combinationally in the same cycle. Loads and stores run a multi-cycle request/acknowledge transaction on the data bus and hold the core with `stallreq` until the result is ready. The block produces the `mem_*` result bundle that `wb` registers into the regfile and hilo_reg.

## Interface
- No parameters; widths come from `defines.v` (`RegBus`=32, `RegAddrBus`=5, `AluOpBus`=8).
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `ex_wd` in 5: destination register.
- `ex_wreg` in 1: register write enable.
- `ex_wdata` in 32: ALU result.
- `ex_hi` / `ex_lo` in 32 each: HI and LO write data.
- `ex_whilo` in 1: HI/LO write enable.
- `ex_aluop` in 8: operation code. Memory ops are `EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP`.
- `ex_mem_addr` in 32: effective address.
- `ex_reg2` in 32: store data.
- `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_hi`, `mem_lo`, `mem_whilo` out: result bundle to `wb`. Widths match the `ex_*` equivalents.
- `stallreq` out 1: hold PC and upstream stages.
- `dbus_req` out 1: bus request.
- `dbus_we` out 1: 1 = write.
- `dbus_addr` out 32: word address, with bits [1:0] = 0.
- `dbus_sel` out 4: byte lane enables. Bit 3 is lane [31:24].
- `dbus_wdata` out 32: write data, replicated to every lane.
- `dbus_ack` in 1: transfer complete. Sampled only while `dbus_req` = 1.
- `dbus_rdata` in 32: read data, valid while `dbus_ack` = 1.
- `mem_misalign` out 1: misaligned access flag (see Configuration).

## Operation
- **FSM states:** IDLE, BUS, DONE.
- **Reset:** state = IDLE. Bus registers `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_sel`, `dbus_wdata` and the load buffer are all 0.
  - While `rst` = 1, all combinational outputs are forced to 0: `mem_*` bundle, `stallreq`, `mem_misalign`.
- **IDLE, non-memory op:**
  - `mem_*` = `ex_*`, combinationally.
  - `stallreq` = 0.
- **IDLE, memory op:**
  - `stallreq` = 1 and `mem_wreg` = 0.
  - Next edge: load the bus registers and go to BUS.
- **BUS:**
  - `dbus_req` = 1 and `stallreq` = 1.
  - Stay in BUS while `dbus_ack` = 0.
  - On the ack edge: capture `dbus_rdata` into the load buffer, clear `dbus_req`, go to DONE.
- **DONE:**
  - `stallreq` = 0, so the instruction commits this cycle.
  - Load: `mem_wdata` = extracted and extended buffer value; `mem_wreg` = `ex_wreg`.
  - Store: `mem_wreg` = 0.
  - Next edge: go to IDLE.
- **Lane mapping (big-endian):**
  - Byte ops: addr[1:0] 00/01/10/11 → `dbus_sel` 1000/0100/0010/0001.
  - Halfword ops: addr[1] 0 → 1100, 1 → 0011.
  - Word ops: 1111.
- **Load extension:**
  - LB and LH sign-extend from the selected lane.
  - LBU and LHU zero-extend.
  - LW uses all 32 bits.
- **Store data:** SB replicates `ex_reg2[7:0]` ×4. SH replicates `ex_reg2[15:0]` ×2.
- **HI/LO:** `mem_hi`, `mem_lo` and `mem_whilo` always pass through from `ex_*`. They are gated to 0 only by `rst`.

## Timing
- Non-memory op: 0-cycle latency.
- Memory op: 2 + N cycles, where N ≥ 1 is the number of BUS cycles up to and including the ack cycle. The minimum is 3 cycles.
- Upstream holds the `ex_*` inputs stable while `stallreq` = 1.
- The bus side holds `dbus_ack` = 0 when `dbus_req` = 0. An ack outside BUS is ignored.
- Reset mid-transaction: the FSM returns to IDLE and `dbus_req` drops on that edge. A late ack is ignored.
- Back-to-back memory ops: DONE → IDLE → next transaction. There is no bubble beyond the IDLE detect cycle.

## Configuration
- **Macro:** `MEM_ALIGN_CHECK_EN`.
- **Defined:**
  - Misaligned accesses are LH/LHU/SH with addr[0] = 1, and LW/SW with addr[1:0] ≠ 0.
  - On a misaligned access, the block stays in IDLE with no bus access and no stall.
  - `mem_wreg` = 0 and `mem_misalign` = 1 for that cycle.
- **Undefined:**
  - `mem_misalign` is tied to 0.
  - Halfword ops ignore addr[0]; word ops ignore addr[1:0].

## Test plan
- **ALU passthrough:** `ex_aluop` = add, `ex_wd` = 5, `ex_wdata` = 0x1234 → same cycle `mem_wd` = 5, `mem_wdata` = 0x1234, `stallreq` = 0, `dbus_req` never asserts.
- **Signed byte load:** LB, addr 0x101, rdata 0x11F233 44, ack on 1st BUS cycle → `dbus_sel` = 0100, `dbus_addr` = 0x100, `stallreq` high for 2 cycles, DONE `mem_wdata` = 0xFFFFFFF2.
- **Halfword store with wait:** SH, addr 0x202, `ex_reg2` = 0xAAAABEEF, ack after 3 BUS cycles → `dbus_we` = 1, `dbus_sel` = 0011, `dbus_wdata` = 0xBEEFBEEF, total 5 cycles, `mem_wreg` = 0.
- **Reset mid-transaction:** `rst` asserted during BUS, then ack → `dbus_req` = 0 after the edge, IDLE, outputs 0, no writeback.
- **Misaligned word load:** LW at 0x103 with `MEM_ALIGN_CHECK_EN` → `mem_misalign` = 1, no `dbus_req`, `mem_wreg` = 0. Without the macro → access at 0x100 with sel 1111.
- **Load then HI/LO:** LHU 0x8001 at addr 0x0, followed by a MTHI with `ex_hi` = 7 → `mem_wdata` = 0x00008001, then `mem_whilo` = 1 and `mem_hi` = 7 with no stall.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory-access stage between execute and writeback.
// Non-memory ops pass straight through in the same cycle. Loads and stores run a
// req/ack transaction on the data bus while holding the core with stallreq.
// The bus is big-endian: byte lane 3 (dbus_sel[3]) is data bits [31:24].
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned halfword/word
// accesses. A flagged access is suppressed and never reaches the bus.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_misalign
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_e;

  state_e      state_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, rbuf_q;
  logic [3:0]  sel_q;
  logic [1:0]  off_q;

  logic        is_load, is_store, is_mem, is_half, is_word, misalign, start;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d;

  // Pick the selected lane out of the buffered word and extend it per load type.
  function automatic logic [31:0] load_ext(input logic [7:0] op, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (op)
      EXE_LB_OP:  return {{24{b[7]}}, b};
      EXE_LBU_OP: return {24'd0, b};
      EXE_LH_OP:  return {{16{h[15]}}, h};
      EXE_LHU_OP: return {16'd0, h};
      default:    return word;
    endcase
  endfunction

  // Decode the op class, lane enables, replicated store data and alignment.
  always_comb begin
    is_load  = ex_aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    is_store = ex_aluop inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    is_mem   = is_load | is_store;
    is_half  = ex_aluop inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
    is_word  = ex_aluop inside {EXE_LW_OP, EXE_SW_OP};
    if (is_word) begin
      sel_d   = 4'b1111;
      wdata_d = ex_reg2;
    end else if (is_half) begin
      sel_d   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      wdata_d = {2{ex_reg2[15:0]}};
    end else begin
      sel_d   = 4'b1000 >> ex_mem_addr[1:0];
      wdata_d = {4{ex_reg2[7:0]}};
    end
`ifdef MEM_ALIGN_CHECK_EN
    misalign = is_mem & ((is_half & ex_mem_addr[0]) | (is_word & (ex_mem_addr[1:0] != 2'b00)));
`else
    misalign = 1'b0;
`endif
    start = (state_q == S_IDLE) & is_mem & ~misalign;
  end

  // Transaction FSM with registered bus outputs and load buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      off_q   <= 2'd0;
      rbuf_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          req_q   <= 1'b1;
          we_q    <= is_store;
          addr_q  <= {ex_mem_addr[31:2], 2'b00};
          sel_q   <= sel_d;
          wdata_q <= wdata_d;
          off_q   <= ex_mem_addr[1:0];
          state_q <= S_BUS;
        end
        S_BUS: if (dbus_ack) begin
          rbuf_q  <= dbus_rdata;
          req_q   <= 1'b0;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_sel   = sel_q;
  assign dbus_wdata = wdata_q;

  // Result bundle and stall: pass through by default, gate writes during memory ops.
  always_comb begin
    mem_wd       = ex_wd;
    mem_wreg     = ex_wreg;
    mem_wdata    = ex_wdata;
    mem_hi       = ex_hi;
    mem_lo       = ex_lo;
    mem_whilo    = ex_whilo;
    stallreq     = 1'b0;
    mem_misalign = 1'b0;
    if (rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
      mem_hi    = 32'd0;
      mem_lo    = 32'd0;
      mem_whilo = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (is_mem) begin
          mem_wreg     = 1'b0;
          stallreq     = ~misalign;
          mem_misalign = misalign;
        end
        S_BUS: begin
          mem_wreg = 1'b0;
          stallreq = 1'b1;
        end
        default: begin
          if (is_load) mem_wdata = load_ext(ex_aluop, off_q, rbuf_q);
          else         mem_wreg  = 1'b0;
        end
      endcase
    end
  end

endmodule
